// File: rtl/elevator_call_scheduler_if.sv
// Bundle of call, position, handshake and status signals between the scheduler and its neighbours.
// The slave modport is the scheduler's view of the bundle; the master modport is the environment's view.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  step_ack;
    logic                  step_req;
    logic                  step_dir;
    logic [NUM_FLOORS-1:0] pending;
    logic                  door_open;
    logic                  dir_up;
    logic                  busy;
    logic                  fault;

    modport master (
        output call_req, cur_floor, step_ack,
        input  step_req, step_dir, pending, door_open, dir_up, busy, fault
    );

    modport slave (
        input  call_req, cur_floor, step_ack,
        output step_req, step_dir, pending, door_open, dir_up, busy, fault
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches floor calls, issues one-floor step requests and times the door dwell.
// Define ELEV_DOOR_REOPEN_EN to make a call at the current floor extend an open door's dwell.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 7,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 250_000_000,
    parameter int DOOR_W      = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    elevator_call_scheduler_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_CYCLES - 1);

    logic [1:0]            r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_step_req;
    logic                  r_step_dir;
    logic                  r_door_open;
    logic                  r_dir_up;
    logic                  r_fault;
    logic [DOOR_W-1:0]     r_timer;

    logic [1:0]            w_state_next;
    logic                  w_step_req_next;
    logic                  w_step_dir_next;
    logic                  w_door_next;
    logic                  w_dir_up_next;
    logic [DOOR_W-1:0]     w_timer_next;
    logic                  w_enter_door;

    logic [FLOOR_W:0]      w_cur_ext;
    logic [NUM_FLOORS-1:0] w_here_vec;
    logic [NUM_FLOORS-1:0] w_above_vec;
    logic [NUM_FLOORS-1:0] w_below_vec;
    logic [NUM_FLOORS-1:0] w_clear_mask;
    logic                  w_here;
    logic                  w_above;
    logic                  w_below;
    logic                  w_fault;

    // One extra bit so floor NUM_FLOORS+1 comparisons cannot wrap.
    assign w_cur_ext = {1'b0, bus.cur_floor};

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign w_here_vec[gi]  = (w_cur_ext == (FLOOR_W+1)'(gi + 1));
            assign w_above_vec[gi] = r_pending[gi] && (w_cur_ext <= (FLOOR_W+1)'(gi));
            assign w_below_vec[gi] = r_pending[gi] && (w_cur_ext >= (FLOOR_W+1)'(gi + 2));
        end
    endgenerate

    assign w_here  = |(r_pending & w_here_vec);
    assign w_above = |w_above_vec;
    assign w_below = |w_below_vec;
    assign w_fault = (bus.cur_floor == '0) || (w_cur_ext > (FLOOR_W+1)'(NUM_FLOORS));

`ifdef ELEV_DOOR_REOPEN_EN
    logic w_call_here;
    assign w_call_here = |(bus.call_req & w_here_vec);
`endif

    always_comb begin
        w_state_next    = r_state;
        w_step_req_next = r_step_req;
        w_step_dir_next = r_step_dir;
        w_door_next     = r_door_open;
        w_dir_up_next   = r_dir_up;
        w_timer_next    = r_timer;
        w_enter_door    = 1'b0;
        if (w_fault) begin
            w_state_next    = ST_IDLE;
            w_step_req_next = 1'b0;
            w_door_next     = 1'b0;
            w_timer_next    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_here) begin
                        w_enter_door = 1'b1;
                    end else if (w_above && (r_dir_up || !w_below)) begin
                        w_dir_up_next   = 1'b1;
                        w_state_next    = ST_STEP;
                        w_step_req_next = 1'b1;
                        w_step_dir_next = 1'b1;
                    end else if (w_below) begin
                        w_dir_up_next   = 1'b0;
                        w_state_next    = ST_STEP;
                        w_step_req_next = 1'b1;
                        w_step_dir_next = 1'b0;
                    end
                end
                ST_STEP: begin
                    // A continuing move spends one cycle with step_req low before reasserting.
                    if (!r_step_req) begin
                        w_step_req_next = 1'b1;
                        w_step_dir_next = r_dir_up;
                    end else if (bus.step_ack) begin
                        w_step_req_next = 1'b0;
                        if (w_here) begin
                            w_enter_door = 1'b1;
                        end else if (!(r_dir_up ? w_above : w_below)) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                ST_DOOR: begin
`ifdef ELEV_DOOR_REOPEN_EN
                    if (w_call_here) begin
                        w_timer_next = DOOR_LOAD;
                    end else
`endif
                    if (r_timer == '0) begin
                        w_state_next = ST_IDLE;
                        w_door_next  = 1'b0;
                    end else begin
                        w_timer_next = r_timer - DOOR_W'(1);
                    end
                end
                default: begin
                    w_state_next    = ST_IDLE;
                    w_step_req_next = 1'b0;
                    w_door_next     = 1'b0;
                end
            endcase
            if (w_enter_door) begin
                w_state_next = ST_DOOR;
                w_door_next  = 1'b1;
                w_timer_next = DOOR_LOAD;
            end
        end
    end

    // The current floor's call is cleared on the door-entry edge and throughout the dwell.
    assign w_clear_mask = (w_enter_door || r_state == ST_DOOR) ? w_here_vec : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_step_req  <= 1'b0;
            r_step_dir  <= 1'b0;
            r_door_open <= 1'b0;
            r_dir_up    <= 1'b1;
            r_fault     <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= (r_pending | bus.call_req) & ~w_clear_mask;
            r_step_req  <= w_step_req_next;
            r_step_dir  <= w_step_dir_next;
            r_door_open <= w_door_next;
            r_dir_up    <= w_dir_up_next;
            r_fault     <= w_fault;
            r_timer     <= w_timer_next;
        end
    end

    assign bus.step_req  = r_step_req;
    assign bus.step_dir  = r_step_dir;
    assign bus.pending   = r_pending;
    assign bus.door_open = r_door_open;
    assign bus.dir_up    = r_dir_up;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.fault     = r_fault;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with a 4-cycle door dwell.
// A per-cycle vector table covers a first trip; hand sequences cover SCAN order, reopen, reset and fault.
module tb_elevator_call_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    elevator_call_scheduler_if #(.NUM_FLOORS(7), .FLOOR_W(3)) bus_if ();

    elevator_call_scheduler #(
        .NUM_FLOORS (7),
        .FLOOR_W    (3),
        .DOOR_CYCLES(4),
        .DOOR_W     (28)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        logic [6:0]  call_req;
        logic [2:0]  cur_floor;
        logic        step_ack;
        logic [12:0] expect_out;  // {step_req, step_dir, pending, door_open, dir_up, busy, fault}
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [6:0] c, input logic [2:0] f, input logic a,
                                input logic sr, input logic sd, input logic [6:0] p,
                                input logic d, input logic u, input logic b, input logic flt);
        vec_t v;
        v.call_req   = c;
        v.cur_floor  = f;
        v.step_ack   = a;
        v.expect_out = {sr, sd, p, d, u, b, flt};
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {bus_if.step_req, bus_if.step_dir, bus_if.pending, bus_if.door_open,
                bus_if.dir_up, bus_if.busy, bus_if.fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_step_req(input string name);
        int i = 0;
        while (!bus_if.step_req && i < 10) begin
            tick();
            i++;
        end
        check(name, 32'(bus_if.step_req), 32'd1);
    endtask

    // Waits for a step request, checks its direction and acknowledges arrival at new_floor.
    task automatic do_step(input string name, input logic dir, input logic [2:0] new_floor);
        wait_step_req({name, "_req"});
        check({name, "_dir"}, 32'(bus_if.step_dir), 32'(dir));
        bus_if.step_ack  = 1'b1;
        bus_if.cur_floor = new_floor;
        tick();
        bus_if.step_ack  = 1'b0;
        $display("step %s dir=%0d -> floor %0d", name, dir, new_floor);
    endtask

    task automatic measure_door(output int n);
        n = 0;
        while (bus_if.door_open && n < 50) begin
            n++;
            tick();
        end
    endtask

    int door_n;
    int door_total;
    int reopen_expect;

    initial begin
        vecs[0]  = mk(7'h04, 3'd1, 1'b0, 1'b0, 1'b0, 7'h04, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(7'h00, 3'd1, 1'b0, 1'b1, 1'b1, 7'h04, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(7'h00, 3'd1, 1'b0, 1'b1, 1'b1, 7'h04, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(7'h00, 3'd2, 1'b1, 1'b0, 1'b1, 7'h04, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[4]  = mk(7'h00, 3'd2, 1'b0, 1'b1, 1'b1, 7'h04, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(7'h00, 3'd3, 1'b1, 1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(7'h00, 3'd3, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(7'h00, 3'd3, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[8]  = mk(7'h00, 3'd3, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(7'h00, 3'd3, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(7'h00, 3'd3, 1'b1, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef ELEV_DOOR_REOPEN_EN
        reopen_expect = 6;
`else
        reopen_expect = 4;
`endif

        rst = 1'b1;
        bus_if.call_req  = '0;
        bus_if.cur_floor = 3'd1;
        bus_if.step_ack  = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(outs()), 32'(13'b0_0_0000000_0_1_0_0));
        rst = 1'b0;

        // First trip 1 -> 3, one vector per clock.
        for (int i = 0; i < 11; i++) begin
            bus_if.call_req  = vecs[i].call_req;
            bus_if.cur_floor = vecs[i].cur_floor;
            bus_if.step_ack  = vecs[i].step_ack;
            tick();
            $display("vec %0d: call=%h floor=%0d ack=%0d out=%h exp=%h", i, vecs[i].call_req,
                     vecs[i].cur_floor, vecs[i].step_ack, outs(), vecs[i].expect_out);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].expect_out));
        end
        bus_if.step_ack = 1'b0;

        // SCAN: at 4 heading up with calls at 6 and 2 -> 6 first, then down to 2.
        bus_if.cur_floor = 3'd4;
        tick();
        bus_if.call_req = 7'b0100010;
        tick();
        bus_if.call_req = '0;
        do_step("s2_up5", 1'b1, 3'd5);
        do_step("s2_up6", 1'b1, 3'd6);
        check("s2_door6", 32'(bus_if.door_open), 32'd1);
        check("s2_pend6", 32'(bus_if.pending), 32'h02);
        measure_door(door_n);
        check("s2_dwell6", 32'(door_n), 32'd4);
        wait_step_req("s2_rev_req");
        check("s2_dir_up0", 32'(bus_if.dir_up), 32'd0);
        do_step("s2_dn5", 1'b0, 3'd5);
        do_step("s2_dn4", 1'b0, 3'd4);
        do_step("s2_dn3", 1'b0, 3'd3);
        do_step("s2_dn2", 1'b0, 3'd2);
        check("s2_door2", 32'(bus_if.door_open), 32'd1);
        measure_door(door_n);
        check("s2_dwell2", 32'(door_n), 32'd4);
        check("s2_pend_end", 32'(bus_if.pending), 32'h00);

        // Intermediate call for 3 raised mid-move on a 1 -> 5 trip.
        bus_if.cur_floor = 3'd1;
        bus_if.call_req  = 7'b0010000;
        tick();
        bus_if.call_req  = '0;
        wait_step_req("s3_req");
        check("s3_dir", 32'(bus_if.step_dir), 32'd1);
        bus_if.call_req = 7'b0000100;
        tick();
        bus_if.call_req = '0;
        check("s3_pend", 32'(bus_if.pending), 32'h14);
        do_step("s3_up2", 1'b1, 3'd2);
        check("s3_no_door2", 32'(bus_if.door_open), 32'd0);
        do_step("s3_up3", 1'b1, 3'd3);
        check("s3_door3", 32'(bus_if.door_open), 32'd1);
        measure_door(door_n);
        check("s3_dwell3", 32'(door_n), 32'd4);
        do_step("s3_up4", 1'b1, 3'd4);
        do_step("s3_up5", 1'b1, 3'd5);
        check("s3_door5", 32'(bus_if.door_open), 32'd1);
        measure_door(door_n);
        check("s3_dwell5", 32'(door_n), 32'd4);
        check("s3_pend_end", 32'(bus_if.pending), 32'h00);

        // Call for the current floor one cycle into an open door.
        bus_if.cur_floor = 3'd3;
        bus_if.call_req  = 7'b0000100;
        tick();
        bus_if.call_req  = '0;
        tick();
        check("s4_door_c0", 32'(bus_if.door_open), 32'd1);
        tick();
        bus_if.call_req = 7'b0000100;
        tick();
        bus_if.call_req = '0;
        check("s4_pend_cleared", 32'(bus_if.pending), 32'h00);
        measure_door(door_n);
        door_total = 2 + door_n;
        $display("reopen dwell total=%0d expected=%0d", door_total, reopen_expect);
        check("s4_dwell_total", 32'(door_total), 32'(reopen_expect));

        // Reset during a step request; a late ack must be ignored.
        bus_if.call_req = 7'b0100000;
        tick();
        bus_if.call_req = '0;
        wait_step_req("s5_req");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_rst_outs", 32'(outs()), 32'({1'b0, bus_if.step_dir, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
        check("s5_rst_stepdir", 32'(bus_if.step_dir), 32'd0);
        bus_if.step_ack  = 1'b1;
        bus_if.cur_floor = 3'd4;
        tick();
        bus_if.step_ack  = 1'b0;
        check("s5_ack_ignored_busy", 32'(bus_if.busy), 32'd0);
        tick();
        check("s5_ack_ignored_req", 32'(bus_if.step_req), 32'd0);

        // Out-of-range floor with a pending call, then recovery.
        bus_if.cur_floor = 3'd0;
        bus_if.call_req  = 7'b0001000;
        tick();
        bus_if.call_req  = '0;
        check("s6_fault", 32'(bus_if.fault), 32'd1);
        tick();
        tick();
        check("s6_no_req", 32'(bus_if.step_req), 32'd0);
        check("s6_pend_kept", 32'(bus_if.pending), 32'h08);
        check("s6_idle", 32'(bus_if.busy), 32'd0);
        bus_if.cur_floor = 3'd1;
        tick();
        check("s6_fault_clr", 32'(bus_if.fault), 32'd0);
        wait_step_req("s6_req");
        check("s6_dir", 32'(bus_if.step_dir), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Collects floor call requests from switches or buttons and latches them as pending calls.
- Uses a SCAN (directional) policy to decide the next one-floor move for the car.
- Sequences the car-motion datapath one floor at a time through a req/ack handshake.
- Runs the door-open dwell timer. Sits between the input decode and the motion/position logic that feeds the HEX, LED and VGA displays.

Parameters:
- NUM_FLOORS, 7: number of floors, numbered 1..NUM_FLOORS.
- FLOOR_W, 3: floor-number width.
- DOOR_CYCLES, 250_000_000: door dwell length in clk cycles.
- DOOR_W, 28: door-timer width; must hold DOOR_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- call_req  in  NUM_FLOORS  level or pulse; bit i = call for floor i+1
- cur_floor  in  FLOOR_W  current car floor from the motion datapath
- step_ack  in  1  one-cycle pulse; the car finished a one-floor move and cur_floor is already updated in that cycle
- step_req  out  1  request a one-floor move
- step_dir  out  1  1 = up, 0 = down; valid while step_req is high
- pending  out  NUM_FLOORS  latched outstanding calls
- door_open  out  1  door-open indicator
- dir_up  out  1  current SCAN direction
- busy  out  1  high when state is not IDLE
- fault  out  1  cur_floor is out of range

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=IDLE, pending=0, step_req=0, step_dir=0, door_open=0, dir_up=1, busy=0, fault=0, door timer=0.
- Pending update, every edge: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask is the one-hot of cur_floor, applied only in the cycle the FSM enters DOOR or while it is in DOOR.
  - A call raised in the same cycle as a clear for the same floor is cleared; clear wins.
- FSM states: IDLE, STEP, DOOR.
- The FSM evaluates the registered pending value, not the combinational next value. Definitions:
  - above = any pending bit for a floor > cur_floor.
  - below = any pending bit for a floor < cur_floor.
  - here = pending bit for cur_floor.
- IDLE:
  - here → DOOR.
  - Else if above and (dir_up or !below) → dir_up=1, STEP.
  - Else if below → dir_up=0, STEP.
  - Else stay in IDLE.
- STEP:
  - step_req=1 and step_dir=dir_up, both held stable until step_ack.
  - On step_ack: step_req drops on the next edge.
  - Next state after the ack: if pending[new cur_floor] → DOOR; else if further calls exist in dir_up → STEP (step_req reasserts after one cycle low); else IDLE.
  - Direction reverses only from IDLE.
- DOOR:
  - door_open=1. The timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - At 0: door_open drops on the next edge and the FSM goes to IDLE.
  - step_req is never high in DOOR.
- Latency:
  - Call sampled at edge k → pending bit visible after edge k → step_req high after edge k+1.
  - Door open for exactly DOOR_CYCLES cycles.
- Boundaries:
  - step_ack outside STEP is ignored.
  - A call for cur_floor while in STEP is served at the next floor-arrival evaluation, not mid-move.
  - A step_dir up request at floor NUM_FLOORS, or down at floor 1, is never issued.
  - Out of range means cur_floor==0 or cur_floor>NUM_FLOORS. In that case:
    - fault=1 and the FSM forces IDLE.
    - step_req=0.
    - pending keeps latching calls.
    - fault clears when cur_floor is back in range.
- Reset mid-operation: all outputs return to reset values on the next edge and pending is discarded.

Optional Feature:
- Macro: ELEV_DOOR_REOPEN_EN.
- Defined: a call for cur_floor while in DOOR clears that bit and reloads the timer to DOOR_CYCLES-1, extending the dwell.
- Undefined: the call is cleared (absorbed) with no timer change.

Test Plan:
- Bench uses DOOR_CYCLES=4.
- Reset then cur_floor=1, call_req=7'b0000100 (floor 3) for 1 cycle → step_req=1, step_dir=1 two edges after the call. After two step_acks (cur_floor 2, then 3): door_open=1 for 4 cycles, pending=0, state back to IDLE.
- cur_floor=4, pending floors 6 and 2 raised together, dir_up=1 → serves 6 first (two up steps, door), then 2 (dir_up=0, four down steps, door).
- While stepping 1→5 upward, raise a call for floor 3 before the first ack → car stops at 3 (door 4 cycles), then continues to 5.
- In DOOR at floor 3, assert call_req bit 2 two cycles into the dwell → with ELEV_DOOR_REOPEN_EN door_open totals 6 cycles; without it, 4 cycles. pending[2]=0 in both builds.
- Assert rst during STEP with step_req=1 → after the next edge step_req=0, pending=0, busy=0. A later step_ack is ignored.
- cur_floor=0 with a pending call → fault=1, step_req stays 0. Set cur_floor=1 → fault=0 and a step is issued on the following evaluation.
